// File: rtl/dram_pcie_streamer.sv
// Streams COUNT consecutive 512-bit DRAM lines starting at BASE out to PCIe as
// 128-bit beats, configured and started through soft registers.
module dram_pcie_streamer #(
    parameter int unsigned MAX_OUTSTANDING = 8,
    parameter int unsigned LINE_BYTES      = 64
) (
    input  logic         clk,
    input  logic         rst,
    output logic         mem_req_valid,
    output logic         mem_req_isWrite,
    output logic [63:0]  mem_req_addr,
    output logic [511:0] mem_req_data,
    input  logic         mem_req_grant,
    input  logic         mem_resp_valid,
    input  logic [511:0] mem_resp_data,
    output logic         mem_resp_grant,
    output logic         pcie_valid,
    output logic [127:0] pcie_data,
    output logic [15:0]  pcie_slot,
    output logic [3:0]   pcie_pad,
    output logic         pcie_last,
    input  logic         pcie_grant,
    input  logic         sr_req_valid,
    input  logic         sr_req_isWrite,
    input  logic [31:0]  sr_req_addr,
    input  logic [63:0]  sr_req_data,
    output logic         sr_resp_valid,
    output logic [63:0]  sr_resp_data
);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t state, state_next;

    logic [63:0]  cfg_base, run_base;
    logic [31:0]  cfg_count, run_count;
    logic [15:0]  cfg_slot, run_slot;
    logic [31:0]  issued, lines_sent;
    logic [7:0]   outstanding;
    logic [511:0] line_buf;
    logic [1:0]   beat;
    logic         ser_full;
    logic         sr_valid_q;
    logic [63:0]  sr_data_q;
    logic [63:0]  rd_data;

    logic running, sr_wr, cfg_wr, start;
    logic req_fire, resp_fire, beat_fire, line_done;

    always_comb begin
        running   = (state == RUN);
        sr_wr     = sr_req_valid && sr_req_isWrite;
        cfg_wr    = sr_wr && !running;
        start     = cfg_wr && (sr_req_addr == 32'd3);
        req_fire  = mem_req_valid && mem_req_grant;
        beat_fire = pcie_valid && pcie_grant;
        line_done = beat_fire && (beat == 2'd3);
        resp_fire = mem_resp_grant;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE, DONE: if (start) state_next = RUN;
            RUN:        if (lines_sent == run_count) state_next = DONE;
            default:    state_next = IDLE;
        endcase
    end

    // Outputs are gated by rst so they read zero for the whole reset cycle,
    // not just after the clearing edge.
    always_comb begin
        mem_req_valid   = rst && running && (issued < run_count)
                          && (32'(outstanding) < MAX_OUTSTANDING);
        mem_req_isWrite = 1'b0;
        mem_req_data    = '0;
        mem_req_addr    = run_base + 64'(issued) * 64'(LINE_BYTES);
        // Refill in the same cycle the last beat leaves keeps beats back to back.
        mem_resp_grant  = rst && running && mem_resp_valid && (!ser_full || line_done);
        pcie_valid      = rst && ser_full;
        pcie_data       = pcie_valid ? line_buf[{beat, 7'd0} +: 128] : '0;
        pcie_slot       = run_slot;
        pcie_pad        = '0;
        pcie_last       = pcie_valid && (beat == 2'd3) && (lines_sent == run_count - 32'd1);
        sr_resp_valid   = rst && sr_valid_q;
        sr_resp_data    = rst ? sr_data_q : '0;
    end

    always_comb begin
        rd_data = '0;
        case (sr_req_addr)
            32'd0:   rd_data = cfg_base;
            32'd1:   rd_data = {32'd0, cfg_count};
            32'd2:   rd_data = {48'd0, cfg_slot};
            32'd16:  rd_data = {62'd0, state == DONE, state == RUN};
            32'd17:  rd_data = {32'd0, lines_sent};
            default: rd_data = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state       <= IDLE;
            cfg_base    <= '0;
            cfg_count   <= '0;
            cfg_slot    <= '0;
            run_base    <= '0;
            run_count   <= '0;
            run_slot    <= '0;
            issued      <= '0;
            outstanding <= '0;
            lines_sent  <= '0;
            line_buf    <= '0;
            beat        <= '0;
            ser_full    <= 1'b0;
            sr_valid_q  <= 1'b0;
            sr_data_q   <= '0;
        end else begin
            state <= state_next;

            if (cfg_wr) begin
                case (sr_req_addr)
                    32'd0:   cfg_base  <= sr_req_data;
                    32'd1:   cfg_count <= sr_req_data[31:0];
                    32'd2:   cfg_slot  <= sr_req_data[15:0];
                    default: ;
                endcase
            end

            if (start) begin
                run_base    <= cfg_base;
                run_count   <= cfg_count;
                run_slot    <= cfg_slot;
                issued      <= '0;
                outstanding <= '0;
                lines_sent  <= '0;
                beat        <= '0;
                ser_full    <= 1'b0;
            end else begin
                if (req_fire) issued <= issued + 32'd1;

                case ({req_fire, resp_fire})
                    2'b10:   outstanding <= outstanding + 8'd1;
                    2'b01:   outstanding <= outstanding - 8'd1;
                    default: ;
                endcase

                if (resp_fire) begin
                    line_buf <= mem_resp_data;
                    beat     <= '0;
                    ser_full <= 1'b1;
                end else if (beat_fire) begin
                    beat <= beat + 2'd1;
                    if (beat == 2'd3) ser_full <= 1'b0;
                end

                if (line_done) lines_sent <= lines_sent + 32'd1;
            end

            sr_valid_q <= sr_req_valid && !sr_req_isWrite;
            sr_data_q  <= (sr_req_valid && !sr_req_isWrite) ? rd_data : '0;
        end
    end

endmodule

// File: tb/tb_dram_pcie_streamer.sv
// Scoreboard bench: expected requests, beats and register reads are queued
// from a line-level model; a negedge monitor pops and compares DUT outputs.
module tb_dram_pcie_streamer;

    logic         clk = 1'b0;
    logic         rst;
    logic         mem_req_valid, mem_req_isWrite, mem_req_grant;
    logic [63:0]  mem_req_addr;
    logic [511:0] mem_req_data;
    logic         mem_resp_valid, mem_resp_grant;
    logic [511:0] mem_resp_data;
    logic         pcie_valid, pcie_last, pcie_grant;
    logic [127:0] pcie_data;
    logic [15:0]  pcie_slot;
    logic [3:0]   pcie_pad;
    logic         sr_req_valid, sr_req_isWrite;
    logic [31:0]  sr_req_addr;
    logic [63:0]  sr_req_data;
    logic         sr_resp_valid;
    logic [63:0]  sr_resp_data;

    always #5 clk = ~clk;

    dram_pcie_streamer #(.MAX_OUTSTANDING(8), .LINE_BYTES(64)) dut (
        .clk(clk), .rst(rst),
        .mem_req_valid(mem_req_valid), .mem_req_isWrite(mem_req_isWrite),
        .mem_req_addr(mem_req_addr), .mem_req_data(mem_req_data),
        .mem_req_grant(mem_req_grant),
        .mem_resp_valid(mem_resp_valid), .mem_resp_data(mem_resp_data),
        .mem_resp_grant(mem_resp_grant),
        .pcie_valid(pcie_valid), .pcie_data(pcie_data), .pcie_slot(pcie_slot),
        .pcie_pad(pcie_pad), .pcie_last(pcie_last), .pcie_grant(pcie_grant),
        .sr_req_valid(sr_req_valid), .sr_req_isWrite(sr_req_isWrite),
        .sr_req_addr(sr_req_addr), .sr_req_data(sr_req_data),
        .sr_resp_valid(sr_resp_valid), .sr_resp_data(sr_resp_data)
    );

    typedef struct { logic [127:0] data; logic last; } beat_t;
    typedef struct { logic [63:0] data; int due; } srexp_t;

    int checks = 0, errors = 0;
    int cyc = 0;
    logic [63:0] exp_req_q[$];
    beat_t       exp_beat_q[$];
    srexp_t      sr_q[$];
    logic [63:0] mem_q[$];
    logic [15:0] exp_slot;
    logic [63:0] m_base;
    logic [31:0] m_count;
    logic [15:0] m_slot;
    int beats = 0, req_hs = 0, any_req = 0, any_pcie = 0;
    int pg_mode = 0, mg_mode = 0, mem_en = 1, rsp_rand = 0, pg_ctr = 0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [511:0] mem_line(input logic [63:0] a);
        logic [511:0] l;
        for (int i = 0; i < 16; i++)
            l[32*i +: 32] = (a[31:0] * 32'h9E3779B1) ^ a[63:32] ^ (32'(i) * 32'h01010101);
        return l;
    endfunction

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Memory and PCIe sink driver.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            mem_req_grant = (mg_mode == 0) ? 1'b1 : ($urandom_range(0, 3) != 0);
            if (mem_en != 0 && mem_q.size() > 0 && (rsp_rand == 0 || $urandom_range(0, 2) != 0)) begin
                mem_resp_valid = 1'b1;
                mem_resp_data  = mem_line(mem_q[0]);
            end else begin
                mem_resp_valid = 1'b0;
                mem_resp_data  = '0;
            end
            case (pg_mode)
                0: pcie_grant = 1'b1;
                1: begin pcie_grant = (pg_ctr == 2); pg_ctr = (pg_ctr + 1) % 3; end
                default: pcie_grant = 1'($urandom_range(0, 1));
            endcase
        end
    end

    // Monitor.
    initial begin
        logic         prev_stall;
        logic [127:0] prev_data;
        logic [15:0]  prev_slot;
        logic         prev_last;
        srexp_t       e;
        beat_t        b;
        prev_stall = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst) begin
                prev_stall = 1'b0;
            end else begin
                while (sr_q.size() > 0 && sr_q[0].due < cyc) begin
                    checks++; errors++;
                    $display("FAIL sr_resp_missing actual=none required=%0h", sr_q[0].data);
                    void'(sr_q.pop_front());
                end
                if (sr_resp_valid) begin
                    if (sr_q.size() == 0) begin
                        checks++; errors++;
                        $display("FAIL sr_resp_unexpected actual=%0h required=none", sr_resp_data);
                    end else begin
                        e = sr_q.pop_front();
                        check("sr_resp_data", 128'(sr_resp_data), 128'(e.data));
                    end
                end
                if (mem_req_valid) begin
                    any_req++;
                    check("mem_req_write_zero", {127'(mem_req_data != '0), mem_req_isWrite}, '0);
                    if (mem_req_grant) begin
                        req_hs++;
                        if (exp_req_q.size() == 0) begin
                            checks++; errors++;
                            $display("FAIL mem_req_unexpected actual=%0h required=none", mem_req_addr);
                        end else begin
                            check("mem_req_addr", 128'(mem_req_addr), 128'(exp_req_q.pop_front()));
                        end
                        mem_q.push_back(mem_req_addr);
                    end
                end
                if (mem_resp_grant) begin
                    if (!mem_resp_valid || mem_q.size() == 0) begin
                        checks++; errors++;
                        $display("FAIL mem_resp_grant actual=1 required=0");
                    end else begin
                        void'(mem_q.pop_front());
                    end
                end
                if (prev_stall) begin
                    check("stall_valid", 128'(pcie_valid), 128'(1));
                    check("stall_data", pcie_data, prev_data);
                    check("stall_slot_last", {pcie_slot, pcie_last}, {prev_slot, prev_last});
                end
                if (pcie_valid) begin
                    any_pcie++;
                    if (pcie_grant) begin
                        beats++;
                        if (exp_beat_q.size() == 0) begin
                            checks++; errors++;
                            $display("FAIL pcie_beat_unexpected actual=%0h required=none", pcie_data);
                        end else begin
                            b = exp_beat_q.pop_front();
                            check("pcie_data", pcie_data, b.data);
                            check("pcie_last", 128'(pcie_last), 128'(b.last));
                            check("pcie_slot", 128'(pcie_slot), 128'(exp_slot));
                        end
                    end
                    prev_stall = !pcie_grant;
                    prev_data  = pcie_data;
                    prev_slot  = pcie_slot;
                    prev_last  = pcie_last;
                end else begin
                    prev_stall = 1'b0;
                end
            end
        end
    end

    task automatic sr_write(input logic [31:0] a, input logic [63:0] d);
        @(posedge clk); #1;
        sr_req_valid = 1'b1; sr_req_isWrite = 1'b1; sr_req_addr = a; sr_req_data = d;
        @(posedge clk); #1;
        sr_req_valid = 1'b0; sr_req_isWrite = 1'b0;
    endtask

    task automatic sr_read(input logic [31:0] a, input logic [63:0] exp);
        @(posedge clk); #1;
        sr_req_valid = 1'b1; sr_req_isWrite = 1'b0; sr_req_addr = a; sr_req_data = $urandom;
        sr_q.push_back('{data: exp, due: cyc + 1});
        @(posedge clk); #1;
        sr_req_valid = 1'b0;
    endtask

    // Configure and START; the model expands the run into requests and beats.
    task automatic start_run(input logic [63:0] base, input logic [31:0] count, input logic [15:0] slot);
        logic [63:0]  a;
        logic [511:0] l;
        sr_write(0, base);
        sr_write(1, {32'($urandom), count});
        sr_write(2, {48'($urandom), slot});
        m_base = base; m_count = count; m_slot = slot; exp_slot = slot;
        for (int ln = 0; ln < int'(count); ln++) begin
            a = base + 64'(ln) * 64'd64;
            l = mem_line(a);
            exp_req_q.push_back(a);
            for (int bt = 0; bt < 4; bt++)
                exp_beat_q.push_back('{data: l[128*bt +: 128], last: (ln == int'(count) - 1 && bt == 3)});
        end
        sr_write(3, {$urandom, $urandom});
    endtask

    task automatic wait_drain(input int bound);
        int i;
        for (i = 0; i < bound; i++) begin
            @(posedge clk);
            if (exp_beat_q.size() == 0 && exp_req_q.size() == 0) break;
        end
        checks++;
        if (i >= bound) begin
            errors++;
            $display("FAIL drain_timeout actual=%0d_beats_left required=0", exp_beat_q.size());
        end
        repeat (3) @(posedge clk);
    endtask

    task automatic check_regs(input logic [31:0] count);
        sr_read(16, 64'd2);
        sr_read(17, 64'(count));
        sr_read(0, m_base);
        sr_read(1, 64'(m_count));
        sr_read(2, 64'(m_slot));
        sr_read(5, 64'd0);
        repeat (2) @(posedge clk);
    endtask

    task automatic check_outputs_zero(input string name);
        check(name, {mem_req_valid, mem_resp_grant, pcie_valid, pcie_last, sr_resp_valid,
                     1'b0, 58'(pcie_data != '0), sr_resp_data}, '0);
    endtask

    initial begin
        int b0, r0, p0, q0, cnt;
        logic [63:0] base;
        #500000;
        $display("FAIL watchdog actual=timeout required=finish");
        errors++;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $fatal(1);
    end

    initial begin
        int b0, r0, p0, q0, cnt, i;
        logic [63:0] base;
        rst = 1'b0;
        sr_req_valid = 1'b0; sr_req_isWrite = 1'b0; sr_req_addr = '0; sr_req_data = '0;
        mem_req_grant = 1'b0; mem_resp_valid = 1'b0; mem_resp_data = '0; pcie_grant = 1'b0;
        repeat (4) @(posedge clk);
        @(negedge clk);
        check_outputs_zero("reset_outputs");
        @(posedge clk); #1 rst = 1'b1;
        sr_read(16, 64'd0);
        sr_read(17, 64'd0);
        sr_read(0, 64'd0);

        // Directed two-line run, free-flowing sink.
        b0 = beats; r0 = req_hs;
        start_run(64'h1000, 32'd2, 16'd5);
        wait_drain(500);
        check("basic_beats", 128'(beats - b0), 128'(8));
        check("basic_reqs", 128'(req_hs - r0), 128'(2));
        check_regs(2);

        // COUNT == 0: done without any traffic.
        r0 = any_req; p0 = any_pcie;
        sr_write(1, 64'd0);
        m_count = 32'd0;
        sr_write(3, 64'd0);
        sr_read(16, 64'd2);
        sr_read(17, 64'd0);
        repeat (4) @(posedge clk);
        check("zero_count_no_req", 128'(any_req - r0), 128'(0));
        check("zero_count_no_pcie", 128'(any_pcie - p0), 128'(0));

        // Memory silent: request window caps at MAX_OUTSTANDING.
        mem_en = 0;
        r0 = req_hs; b0 = beats;
        start_run(64'h0002_0000_0000_0040, 32'd20, 16'hBEEF);
        repeat (60) @(posedge clk);
        check("outstanding_cap", 128'(req_hs - r0), 128'(8));
        @(negedge clk);
        check("outstanding_cap_valid", 128'(mem_req_valid), 128'(0));
        mem_en = 1;
        wait_drain(3000);
        check("cap_run_beats", 128'(beats - b0), 128'(80));
        check_regs(20);

        // Randomized runs with sink stalls, grant jitter, address wrap and
        // ignored START / config writes mid-run.
        for (int it = 0; it < 8; it++) begin
            pg_mode = it % 3; mg_mode = it % 2; rsp_rand = int'($urandom_range(0, 1));
            base = (it == 3) ? 64'hFFFF_FFFF_FFFF_FF80 : {$urandom, $urandom};
            cnt  = (it % 2 == 1) ? int'($urandom_range(4, 7)) : int'($urandom_range(1, 6));
            b0 = beats;
            start_run(base, 32'(cnt), 16'($urandom));
            if (it % 2 == 1) begin
                sr_write(3, 64'd0);
                sr_write(0, {$urandom, $urandom});
                sr_write(1, 64'd99);
            end
            wait_drain(3000);
            check("rand_beats", 128'(beats - b0), 128'(4 * cnt));
            check_regs(32'(cnt));
        end

        // Reset mid-run after three beats, then a clean transfer.
        pg_mode = 0; mg_mode = 0; rsp_rand = 0;
        b0 = beats;
        start_run(64'h0000_0000_00AB_0000, 32'd4, 16'd9);
        for (i = 0; i < 500; i++) begin
            @(posedge clk);
            if (beats - b0 >= 3) break;
        end
        check("reset_wait", 128'(i < 500), 128'(1));
        #1 rst = 1'b0;
        exp_beat_q.delete();
        exp_req_q.delete();
        @(negedge clk);
        check_outputs_zero("midrun_reset_outputs");
        @(posedge clk); @(posedge clk); #1 rst = 1'b1;
        q0 = mem_q.size();
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check("post_reset_no_resp_grant", 128'(mem_resp_grant), 128'(0));
        end
        sr_read(16, 64'd0);
        sr_read(17, 64'd0);
        mem_en = 0;
        @(posedge clk); #1 mem_q.delete();
        mem_en = 1;
        b0 = beats;
        start_run(64'h0000_0000_0CAF_E000, 32'd3, 16'd12);
        wait_drain(1000);
        check("fresh_run_beats", 128'(beats - b0), 128'(12));
        check_regs(3);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/dram_pcie_streamer.md
DRAM_PCIE_STREAMER -- requirements
Module: dram_pcie_streamer

Interface
REQ-001 SHALL have parameter MAX_OUTSTANDING, default 8, meaning the maximum number of read requests granted but not yet answered (range 1-255).
REQ-002 SHALL have parameter LINE_BYTES, default 64, meaning the address increment per 512-bit line.
REQ-003 SHALL have port clk  in  1  rising-edge clock.
REQ-004 SHALL have port rst  in  1  reset, synchronous, active-low.
REQ-005 SHALL have port mem_req_valid  out  1  read request valid.
REQ-006 SHALL have port mem_req_isWrite  out  1  always 0.
REQ-007 SHALL have port mem_req_addr  out  64  byte address of the line.
REQ-008 SHALL have port mem_req_data  out  512  always 0.
REQ-009 SHALL have port mem_req_grant  in  1  request accepted this cycle.
REQ-010 SHALL have port mem_resp_valid  in  1  read data available.
REQ-011 SHALL have port mem_resp_data  in  512  read data.
REQ-012 SHALL have port mem_resp_grant  out  1  dequeue the response.
REQ-013 SHALL have port pcie_valid  out  1  PCIe packet valid.
REQ-014 SHALL have port pcie_data  out  128  beat data.
REQ-015 SHALL have port pcie_slot  out  16  destination slot.
REQ-016 SHALL have port pcie_pad  out  4  always 0.
REQ-017 SHALL have port pcie_last  out  1  final beat of the transfer.
REQ-018 SHALL have port pcie_grant  in  1  beat accepted this cycle.
REQ-019 SHALL have port sr_req_valid / sr_req_isWrite / sr_req_addr / sr_req_data  in  1/1/32/64  soft register request.
REQ-020 SHALL have port sr_resp_valid / sr_resp_data  out  1/64  soft register read response.

Function
REQ-021 SHALL decode soft register writes as follows: addr 0 = BASE[63:0]; addr 1 = COUNT (lines, low 32 bits); addr 2 = SLOT (low 16 bits); addr 3 = START (data ignored).
REQ-022 SHALL decode soft register reads as follows: addr 0-2 = the configuration registers; addr 16 = {62'b0, done, busy}; addr 17 = lines sent (32 bits, zero-extended); any other addr = 0.
REQ-023 SHALL assert sr_resp_valid exactly one cycle after a read request, and only for reads.
REQ-024 SHALL implement the FSM IDLE -> RUN on START; RUN -> DONE when lines_sent == COUNT; DONE -> RUN on START.
REQ-025 SHALL ignore START while in RUN.
REQ-026 SHALL ignore writes to addr 0-2 while in RUN.
REQ-027 SHALL treat START with COUNT == 0 as RUN -> DONE on the next cycle, with no memory or PCIe traffic.
REQ-028 SHALL, on each START, clear issued, outstanding, lines_sent and done, and latch BASE, COUNT and SLOT for the run.
REQ-029 SHALL assert mem_req_valid in RUN while issued < COUNT and outstanding < MAX_OUTSTANDING.
REQ-030 SHALL drive mem_req_addr = BASE + issued*LINE_BYTES (64-bit wrap) and hold it stable until grant.
REQ-031 SHALL count a request as issued only when mem_req_valid and mem_req_grant are both 1.
REQ-032 SHALL increment outstanding on request handshake and decrement it on response handshake; simultaneous handshakes leave it unchanged.
REQ-033 SHALL buffer one line in a 4-beat serializer.
REQ-034 SHALL assert mem_resp_grant only when mem_resp_valid is 1 and the serializer is empty, or is emitting beat 3 while pcie_grant is 1 (zero-bubble refill).
REQ-035 SHALL emit the serializer beats in order data[127:0], [255:128], [383:256], [511:384], advancing the beat only on pcie_valid && pcie_grant.
REQ-036 SHALL hold pcie_data, pcie_slot and pcie_last stable while pcie_valid is 1 and pcie_grant is 0.
REQ-037 SHALL drive pcie_slot = the latched SLOT.
REQ-038 SHALL assert pcie_last only on beat 3 of line COUNT-1.
REQ-039 SHALL increment lines_sent on the handshake of beat 3.
REQ-040 SHALL deliver the first beat no earlier than 1 cycle after the response handshake, with sustained throughput of 1 beat per cycle when pcie_grant is held high.
REQ-041 SHALL accept mem_resp data arriving in request order without reordering.

Reset
REQ-042 SHALL, on rst == 0 at a clock edge: FSM = IDLE; BASE, COUNT, SLOT, issued, outstanding and lines_sent = 0; serializer empty.
REQ-043 SHALL drive all valid and grant outputs to 0, pcie_data and sr_resp_data to 0, and status to 0 while rst == 0.
REQ-044 SHALL, on reset asserted mid-run, abandon the run immediately and drop any subsequent mem_resp without granting it.

Verification
REQ-045 SHALL be verified with: BASE=0x1000, COUNT=2, SLOT=5, START, memory model with 1-cycle latency, pcie_grant=1 -> requests to 0x1000 and 0x1040; 8 beats on slot 5; last only on beat 8; status reads 0b10; lines sent reads 2.
REQ-046 SHALL be verified with: COUNT=0, START -> no mem_req_valid, no pcie_valid; status reads done=1 after 2 cycles.
REQ-047 SHALL be verified with: COUNT=20, memory never responds -> exactly MAX_OUTSTANDING=8 grants, then mem_req_valid stays 0.
REQ-048 SHALL be verified with: pcie_grant toggling 1 in 3 cycles -> beat order and values preserved, data stable while stalled, 4*COUNT beats total.
REQ-049 SHALL be verified with: START during RUN, and a write to addr 0 during RUN -> both ignored; run completes with the original parameters.
REQ-050 SHALL be verified with: rst pulsed low after 3 beats -> all outputs 0 next cycle; a fresh START then sends the full transfer correctly.
